// File: rtl/servo_xy_pkg.sv
// servo_xy_pkg: shared types, limits and helpers for the XY servo
// sequencer (FSM state enum, position/width sizing, clamp/slew/width math).
package servo_xy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    X_PULSE,
    Y_PULSE,
    GAP
  } state_e;

  localparam int POS_MAX    = 250;
  localparam int POS_CENTER = 125;
  localparam int POS_W      = 8;
  localparam int WIDTH_W    = 12;

  function automatic logic [POS_W-1:0] clamp_pos(
    input logic [POS_W-1:0] pos
  );
    return (pos > POS_W'(POS_MAX)) ? POS_W'(POS_MAX) : pos;
  endfunction

  function automatic logic [WIDTH_W-1:0] pos_width(
    input logic [POS_W-1:0] pos,
    input int               min_us,
    input int               us_per_pos
  );
    return WIDTH_W'(min_us) + WIDTH_W'(pos) * WIDTH_W'(us_per_pos);
  endfunction

  // Move cur toward tgt by at most step.
  function automatic logic [POS_W-1:0] slew_toward(
    input logic [POS_W-1:0] cur,
    input logic [POS_W-1:0] tgt,
    input int               step
  );
    int c;
    int t;
    c = int'(cur);
    t = int'(tgt);
    if (t > c + step) return POS_W'(c + step);
    if (t < c - step) return POS_W'(c - step);
    return tgt;
  endfunction

endpackage

// File: rtl/servo_us_tick.sv
// servo_us_tick: CLK_DIV prescaler producing a 1 us tick, plus the us frame
// counter that wraps FRAME_US-1 -> 0.
// Ports: clk_i, reset_i (async, active-high), restart_i (zero the frame
// counter on this tick), tick_o, wrap_o (tick at FRAME_US-1), us_cnt_o.
module servo_us_tick #(
  parameter int CLK_DIV  = 10,
  parameter int FRAME_US = 20000,
  parameter int UW       = $clog2(FRAME_US)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          restart_i,
  output logic          tick_o,
  output logic          wrap_o,
  output logic [UW-1:0] us_cnt_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [UW-1:0] us_q, us_d;

  assign tick_o   = (pre_q == PW'(CLK_DIV - 1));
  assign wrap_o   = tick_o && (us_q == UW'(FRAME_US - 1));
  assign us_cnt_o = us_q;

  always_comb begin
    pre_d = tick_o ? '0 : pre_q + PW'(1);
    us_d  = us_q;
    if (tick_o) begin
      us_d = (restart_i || wrap_o) ? '0 : us_q + UW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pre_q <= '0;
      us_q  <= '0;
    end else begin
      pre_q <= pre_d;
      us_q  <= us_d;
    end
  end

endmodule

// File: rtl/servo_xy_sequencer.sv
// servo_xy_sequencer: one shared us timer time-multiplexed per frame into
// an X pulse, a Y pulse and an idle gap; commands arrive over valid/ready
// into a one-entry holding register and are applied at frame start.
// Ports: clk_i, reset_i (async, active-high), enable_i, cmd_valid_i,
// cmd_ready_o, cmd_x_i, cmd_y_i, servo_x_o, servo_y_o, frame_o, busy_o,
// cur_x_o, cur_y_o.
// Build option: define SERVO_XY_SLEW_EN to limit motion to STEP per frame;
// otherwise the current position jumps to the target at frame start.
module servo_xy_sequencer
  import servo_xy_pkg::*;
#(
  parameter int CLK_DIV    = 10,
  parameter int FRAME_US   = 20000,
  parameter int MIN_US     = 1000,
  parameter int US_PER_POS = 4,
  parameter int STEP       = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [POS_W-1:0] cmd_x_i,
  input  logic [POS_W-1:0] cmd_y_i,
  output logic             servo_x_o,
  output logic             servo_y_o,
  output logic             frame_o,
  output logic             busy_o,
  output logic [POS_W-1:0] cur_x_o,
  output logic [POS_W-1:0] cur_y_o
);

  localparam int UW = $clog2(FRAME_US);
  localparam logic [WIDTH_W-1:0] W_CTR =
    WIDTH_W'(MIN_US + POS_CENTER * US_PER_POS);

`ifdef SERVO_XY_SLEW_EN
  localparam int SLEW_LIM = STEP;
`else
  // A step wider than the position range lands cur on tgt in one frame.
  localparam int SLEW_LIM = POS_MAX + STEP;
`endif

  state_e state_q, state_d;

  logic          tick;
  logic          wrap;
  logic [UW-1:0] us_cnt;
  logic          restart;
  logic          fs;
  logic          x_done;
  logic          y_done;

  logic [POS_W-1:0] cur_x_q, cur_x_d;
  logic [POS_W-1:0] cur_y_q, cur_y_d;
  logic [POS_W-1:0] tgt_x_q, tgt_x_d;
  logic [POS_W-1:0] tgt_y_q, tgt_y_d;
  logic [POS_W-1:0] hold_x_q, hold_x_d;
  logic [POS_W-1:0] hold_y_q, hold_y_d;
  logic             hold_v_q, hold_v_d;
  logic [WIDTH_W-1:0] wx_q, wx_d;
  logic [WIDTH_W-1:0] wend_q, wend_d;
  logic busy_q, busy_d;
  logic frame_q;
  logic servo_x_q;
  logic servo_y_q;

  logic             accept;
  logic [POS_W-1:0] cmd_x_c;
  logic [POS_W-1:0] cmd_y_c;

  servo_us_tick #(
    .CLK_DIV  (CLK_DIV),
    .FRAME_US (FRAME_US),
    .UW       (UW)
  ) u_tick (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .restart_i (restart),
    .tick_o    (tick),
    .wrap_o    (wrap),
    .us_cnt_o  (us_cnt)
  );

  // Pulse ends on the tick that completes its last us of the frame.
  assign x_done = (32'(us_cnt) == 32'(wx_q) - 32'd1);
  assign y_done = (32'(us_cnt) == 32'(wend_q) - 32'd1);

  always_comb begin
    state_d = state_q;
    fs      = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Starting from idle realigns the frame counter to this tick.
        if (tick && enable_i) begin
          state_d = X_PULSE;
          fs      = 1'b1;
          restart = 1'b1;
        end
      end
      X_PULSE: begin
        if (tick && x_done) state_d = Y_PULSE;
      end
      Y_PULSE: begin
        if (tick && y_done) state_d = GAP;
      end
      GAP: begin
        if (wrap) begin
          if (enable_i) begin
            state_d = X_PULSE;
            fs      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept  = cmd_valid_i && !hold_v_q;
  assign cmd_x_c = clamp_pos(cmd_x_i);
  assign cmd_y_c = clamp_pos(cmd_y_i);

  always_comb begin
    hold_x_d = hold_x_q;
    hold_y_d = hold_y_q;
    hold_v_d = hold_v_q;
    tgt_x_d  = tgt_x_q;
    tgt_y_d  = tgt_y_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    wx_d     = wx_q;
    wend_d   = wend_q;
    if (fs) begin
      if (hold_v_q) begin
        tgt_x_d  = hold_x_q;
        tgt_y_d  = hold_y_q;
        hold_v_d = 1'b0;
      end else if (accept) begin
        // Same-cycle command skips the holding register.
        tgt_x_d = cmd_x_c;
        tgt_y_d = cmd_y_c;
      end
      cur_x_d = slew_toward(cur_x_q, tgt_x_d, SLEW_LIM);
      cur_y_d = slew_toward(cur_y_q, tgt_y_d, SLEW_LIM);
      wx_d    = pos_width(cur_x_d, MIN_US, US_PER_POS);
      wend_d  = wx_d + pos_width(cur_y_d, MIN_US, US_PER_POS);
    end else if (accept) begin
      hold_x_d = cmd_x_c;
      hold_y_d = cmd_y_c;
      hold_v_d = 1'b1;
    end
`ifdef SERVO_XY_SLEW_EN
    busy_d = (cur_x_d != tgt_x_d) || (cur_y_d != tgt_y_d);
`else
    // cur tracks tgt each frame, so only a pending command means motion.
    busy_d = hold_v_d || (cur_x_d != tgt_x_d) || (cur_y_d != tgt_y_d);
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cur_x_q   <= POS_W'(POS_CENTER);
      cur_y_q   <= POS_W'(POS_CENTER);
      tgt_x_q   <= POS_W'(POS_CENTER);
      tgt_y_q   <= POS_W'(POS_CENTER);
      hold_x_q  <= '0;
      hold_y_q  <= '0;
      hold_v_q  <= 1'b0;
      wx_q      <= W_CTR;
      wend_q    <= W_CTR + W_CTR;
      busy_q    <= 1'b0;
      frame_q   <= 1'b0;
      servo_x_q <= 1'b0;
      servo_y_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      hold_x_q  <= hold_x_d;
      hold_y_q  <= hold_y_d;
      hold_v_q  <= hold_v_d;
      wx_q      <= wx_d;
      wend_q    <= wend_d;
      busy_q    <= busy_d;
      frame_q   <= fs;
      servo_x_q <= (state_d == X_PULSE);
      servo_y_q <= (state_d == Y_PULSE);
    end
  end

  assign servo_x_o   = servo_x_q;
  assign servo_y_o   = servo_y_q;
  assign frame_o     = frame_q;
  assign busy_o      = busy_q;
  assign cmd_ready_o = !hold_v_q;
  assign cur_x_o     = cur_x_q;
  assign cur_y_o     = cur_y_q;

endmodule

// File: tb/tb_servo_xy_sequencer.sv
// tb_servo_xy_sequencer: scoreboard bench for servo_xy_sequencer with a
// shortened frame (CLK_DIV=2, FRAME_US=520, MIN_US=4, US_PER_POS=1).
module tb_servo_xy_sequencer;

  localparam int CLK_DIV    = 2;
  localparam int FRAME_US   = 520;
  localparam int MIN_US     = 4;
  localparam int US_PER_POS = 1;
  localparam int STEP       = 4;
  localparam int P          = CLK_DIV * FRAME_US;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic       cmd_valid_i;
  logic [7:0] cmd_x_i;
  logic [7:0] cmd_y_i;
  logic       cmd_ready_o;
  logic       servo_x_o;
  logic       servo_y_o;
  logic       frame_o;
  logic       busy_o;
  logic [7:0] cur_x_o;
  logic [7:0] cur_y_o;

  always #5 clk = ~clk;

  servo_xy_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_US   (FRAME_US),
    .MIN_US     (MIN_US),
    .US_PER_POS (US_PER_POS),
    .STEP       (STEP)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_x_i     (cmd_x_i),
    .cmd_y_i     (cmd_y_i),
    .servo_x_o   (servo_x_o),
    .servo_y_o   (servo_y_o),
    .frame_o     (frame_o),
    .busy_o      (busy_o),
    .cur_x_o     (cur_x_o),
    .cur_y_o     (cur_y_o)
  );

  typedef struct {
    int wx;
    int wy;
  } frm_t;

  frm_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  int m_cur_x, m_cur_y, m_tgt_x, m_tgt_y;
  int m_hold_x, m_hold_y, m_byp_x, m_byp_y;
  bit m_hold_v, m_byp_v;
  int last_wx = 0;
  int n_frames = 0;
  int cyc = 0;
  int last_fr = 0;
  bit per_ok = 0;
  int xcnt = 0;
  int ycnt = 0;
  int xw = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > 250) ? 250 : v;
  endfunction

  function automatic int step_to(input int c, input int t);
`ifdef SERVO_XY_SLEW_EN
    if (t > c) return (t - c > STEP) ? c + STEP : t;
    if (t < c) return (c - t > STEP) ? c - STEP : t;
    return t;
`else
    return (c == t) ? c : t;
`endif
  endfunction

  function automatic int m_busy();
`ifdef SERVO_XY_SLEW_EN
    return int'((m_cur_x != m_tgt_x) || (m_cur_y != m_tgt_y));
`else
    return int'(m_hold_v);
`endif
  endfunction

  task automatic model_reset();
    m_cur_x  = 125;
    m_cur_y  = 125;
    m_tgt_x  = 125;
    m_tgt_y  = 125;
    m_hold_v = 0;
    m_byp_v  = 0;
  endtask

  always @(posedge clk) cyc++;

  // Frame model and pulse-width monitor.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (frame_o) begin
        if (m_hold_v) begin
          m_tgt_x  = m_hold_x;
          m_tgt_y  = m_hold_y;
          m_hold_v = 0;
        end else if (m_byp_v) begin
          m_tgt_x = m_byp_x;
          m_tgt_y = m_byp_y;
          m_byp_v = 0;
        end
        m_cur_x = step_to(m_cur_x, m_tgt_x);
        m_cur_y = step_to(m_cur_y, m_tgt_y);
        last_wx = MIN_US + m_cur_x * US_PER_POS;
        sbq.push_back('{last_wx, MIN_US + m_cur_y * US_PER_POS});
        check("cur_x", int'(cur_x_o), m_cur_x);
        check("cur_y", int'(cur_y_o), m_cur_y);
        check("busy", int'(busy_o), m_busy());
        if (per_ok) check("period", cyc - last_fr, P);
        last_fr = cyc;
        per_ok  = 1;
        n_frames++;
      end
      if (servo_x_o) xcnt++;
      else if (xcnt != 0) begin
        xw   = xcnt;
        xcnt = 0;
      end
      if (servo_y_o) ycnt++;
      else if (ycnt != 0) begin
        if (sbq.size() == 0) check("sb_empty", 1, 0);
        else begin
          frm_t e;
          e = sbq.pop_front();
          check("x_width", xw, e.wx * CLK_DIV);
          check("y_width", ycnt, e.wy * CLK_DIV);
        end
        ycnt = 0;
      end
    end
  end

  task automatic wait_frame(input int lim);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      seen = frame_o;
    end
    if (!seen) check("frame_timeout", 0, 1);
    #1;
  endtask

  task automatic drive_cmd(input int x, input int y);
    bit done;
    done = 0;
    @(negedge clk);
    #1;
    cmd_valid_i = 1'b1;
    cmd_x_i     = 8'(x);
    cmd_y_i     = 8'(y);
    for (int i = 0; i < P + 20 && !done; i++) begin
      check("cmd_ready", int'(cmd_ready_o), int'(!m_hold_v));
      @(posedge clk);
      #1;
      if (!m_hold_v) begin
        m_hold_v    = 1;
        m_hold_x    = clampv(x);
        m_hold_y    = clampv(y);
        done        = 1;
        cmd_valid_i = 1'b0;
        check("busy_acc", int'(busy_o), m_busy());
      end else begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      cmd_valid_i = 1'b0;
      check("cmd_timeout", 0, 1);
    end
  endtask

  task automatic settle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      wait_frame(P + 4);
      ok = !m_hold_v && !m_byp_v &&
           m_cur_x == m_tgt_x && m_cur_y == m_tgt_y;
    end
    if (!ok) check("settle_timeout", 0, 1);
  endtask

  initial begin
    int nf;
    bit seen;
    reset_i     = 1'b1;
    enable_i    = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_x_i     = '0;
    cmd_y_i     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_servo_x", int'(servo_x_o), 0);
    check("rst_servo_y", int'(servo_y_o), 0);
    check("rst_frame", int'(frame_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_ready", int'(cmd_ready_o), 1);
    check("rst_cur_x", int'(cur_x_o), 125);
    check("rst_cur_y", int'(cur_y_o), 125);

    // Free-running frames at center.
    reset_i  = 1'b0;
    enable_i = 1'b1;
    wait_frame(CLK_DIV + 2);
    wait_frame(P + 4);
    wait_frame(P + 4);

    // Full-range move, then clamp of an out-of-range X.
    drive_cmd(0, 250);
    settle();
    check("move_x", int'(cur_x_o), 0);
    check("move_y", int'(cur_y_o), 250);
    drive_cmd(255, 250);
    settle();
    check("clamp_x", int'(cur_x_o), 250);
    wait_frame(P + 4);

    // Back-to-back: second command stalls until the next frame.
    drive_cmd(10, 20);
    drive_cmd(30, 40);
    settle();
    check("b2b_x", int'(cur_x_o), 30);
    check("b2b_y", int'(cur_y_o), 40);

    // Command landing exactly on the frame start cycle.
    wait_frame(P + 4);
    repeat (P - 1) @(negedge clk);
    check("byp_ready_pre", int'(cmd_ready_o), int'(!m_hold_v));
    cmd_valid_i = 1'b1;
    cmd_x_i     = 8'd200;
    cmd_y_i     = 8'd50;
    @(posedge clk);
    #1;
    m_byp_v     = 1;
    m_byp_x     = 200;
    m_byp_y     = 50;
    cmd_valid_i = 1'b0;
    @(negedge clk);
    #1;
    check("byp_ready_post", int'(cmd_ready_o), 1);
    check("byp_frame", int'(frame_o), 1);
    settle();
    check("byp_x", int'(cur_x_o), 200);
    check("byp_y", int'(cur_y_o), 50);

    // Disable mid X pulse: frame completes, then idle.
    wait_frame(P + 4);
    repeat (last_wx * CLK_DIV / 2) @(negedge clk);
    enable_i = 1'b0;
    per_ok   = 0;
    nf       = n_frames;
    repeat (2 * P) @(negedge clk);
    #1;
    check("idle_frames", n_frames, nf);
    check("idle_x", int'(servo_x_o), 0);
    check("idle_y", int'(servo_y_o), 0);
    check("idle_sb", sbq.size(), 0);
    enable_i = 1'b1;
    wait_frame(CLK_DIV + 2);
    wait_frame(P + 4);

    // Reset in the middle of the Y pulse with a command pending.
    drive_cmd(7, 9);
    seen = 0;
    for (int i = 0; i < P + 4 && !seen; i++) begin
      @(negedge clk);
      seen = servo_y_o;
    end
    if (!seen) check("y_timeout", 0, 1);
    repeat (3) @(negedge clk);
    #2;
    reset_i = 1'b1;
    #1;
    check("ry_servo_y", int'(servo_y_o), 0);
    check("ry_servo_x", int'(servo_x_o), 0);
    check("ry_frame", int'(frame_o), 0);
    check("ry_ready", int'(cmd_ready_o), 1);
    check("ry_busy", int'(busy_o), 0);
    check("ry_cur_x", int'(cur_x_o), 125);
    check("ry_cur_y", int'(cur_y_o), 125);
    model_reset();
    xcnt   = 0;
    ycnt   = 0;
    per_ok = 0;
    sbq.delete();
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    wait_frame(CLK_DIV + 2);
    wait_frame(P + 4);
    wait_frame(P + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
